// File: rtl/pc_gen_if.sv
// Fetch-stage control and PC bus for pc_gen.
// Request semantics: each *_valid, ras_push and ras_pop is a single-cycle request.
// It is sampled on the rising clock edge. There is no ready and no back-pressure,
// so every request is consumed, by the priority rules, on the edge it is seen.
interface pc_gen_if #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic            pc_write;
   logic            trap_valid;
   logic [XLEN-1:0] trap_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            ras_push;
   logic [XLEN-1:0] ras_push_addr;
   logic            ras_pop;
   logic [XLEN-1:0] pc;
   logic            ras_hit;
   logic [CW-1:0]   ras_count;
   logic            pc_misaligned;

   // Front-end control side: issues requests and observes the PC.
   modport master (
      output pc_write, trap_valid, trap_pc, redirect_valid, redirect_pc,
             ras_push, ras_push_addr, ras_pop,
      input  pc, ras_hit, ras_count, pc_misaligned
   );

   // PC generator side.
   modport slave (
      input  pc_write, trap_valid, trap_pc, redirect_valid, redirect_pc,
             ras_push, ras_push_addr, ras_pop,
      output pc, ras_hit, ras_count, pc_misaligned
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Next-PC priority is trap, then redirect, then return-address prediction, then sequential.
// A small circular return-address stack (RAS) supplies the return-address predictions.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INC          = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input logic       clk,
   input logic       reset,
   pc_gen_if.slave   bus
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] pc_q;
   logic [PW-1:0]   sp;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];

   logic [PW-1:0]   sp_dec;
   logic [PW-1:0]   wr_idx;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;
   logic            ras_full;
   logic            ras_hit;
   logic            ras_act;
   logic            do_push;
   logic            do_pop;

   assign sp_dec    = sp - PW'(1);
   assign ras_top   = ras_mem[sp_dec];
   assign ras_empty = (count == '0);
   assign ras_full  = (count == CW'(RAS_DEPTH));

   // A prediction is only usable when nothing of higher priority is steering fetch.
   assign ras_hit = bus.ras_pop && !ras_empty && !bus.trap_valid && !bus.redirect_valid;

   // The stack only moves when fetch advances down the predicted path.
   assign ras_act = bus.pc_write && !bus.trap_valid && !bus.redirect_valid && !reset;
   assign do_push = ras_act && bus.ras_push;
   assign do_pop  = ras_act && ras_hit;

   // A push that pairs with a pop replaces the popped top in place.
   assign wr_idx = do_pop ? sp_dec : sp;

   assign bus.pc            = pc_q;
   assign bus.ras_hit       = ras_hit;
   assign bus.ras_count     = count;
   assign bus.pc_misaligned = (pc_q[1:0] != 2'b00);

   // PC register plus stack pointer and occupancy; a trap also flushes the stack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_VECTOR;
         sp    <= '0;
         count <= '0;
      end else if (bus.trap_valid) begin
         pc_q  <= bus.trap_pc;
         sp    <= '0;
         count <= '0;
      end else if (bus.redirect_valid) begin
         pc_q <= bus.redirect_pc;
      end else if (bus.pc_write) begin
         pc_q <= ras_hit ? ras_top : pc_q + XLEN'(INC);
         if (do_push && !do_pop) begin
            sp <= sp + PW'(1);
            if (!ras_full) count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            sp    <= sp_dec;
            count <= count - CW'(1);
         end
      end
   end

   // Stack storage is deliberately left uninitialised; occupancy alone tracks validity.
   always_ff @(posedge clk) begin
      if (do_push) ras_mem[wr_idx] <= bus.ras_push_addr;
   end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_VECTOR = 0x1000 and RAS_DEPTH = 4.
// Each step drives one cycle of inputs and queues the values that should be visible during that cycle.
// A monitor pops the queued values at the falling edge and compares them.
module tb_pc_gen;
   localparam int XLEN = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        hit;
      logic        mis;
      logic [7:0]  id;
   } exp_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;
   exp_t exp_q[$];

   pc_gen_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

   pc_gen #(
      .XLEN(XLEN), .RESET_VECTOR(32'h0000_1000), .INC(4), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d required 0", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h required %h", name, id, act, req);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val("pc", e.id, bus.pc, e.pc);
         check_val("ras_count", e.id, 32'(bus.ras_count), 32'(e.cnt));
         check_val("ras_hit", e.id, 32'(bus.ras_hit), 32'(e.hit));
         check_val("pc_misaligned", e.id, 32'(bus.pc_misaligned), 32'(e.mis));
      end
   end

   // driver: apply one cycle of inputs just after the rising edge and queue the expected view
   task automatic step(input logic pw, input logic tv, input logic [31:0] tpc,
                       input logic rv, input logic [31:0] rpc,
                       input logic push, input logic [31:0] paddr, input logic pop,
                       input logic rst,
                       input logic [31:0] epc, input logic [2:0] ecnt, input logic ehit);
      exp_t e;
      @(posedge clk);
      #1;
      reset              = rst;
      bus.pc_write       = pw;
      bus.trap_valid     = tv;
      bus.trap_pc        = tpc;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.ras_push       = push;
      bus.ras_push_addr  = paddr;
      bus.ras_pop        = pop;
      step_id++;
      e.pc  = epc;
      e.cnt = ecnt;
      e.hit = ehit;
      e.mis = (epc[1:0] != 2'b00);
      e.id  = 8'(step_id);
      exp_q.push_back(e);
   endtask

   initial begin
      reset              = 1'b1;
      bus.pc_write       = 1'b0;
      bus.trap_valid     = 1'b0;
      bus.trap_pc        = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.ras_push       = 1'b0;
      bus.ras_push_addr  = '0;
      bus.ras_pop        = 1'b0;
      repeat (2) @(posedge clk);

      //    pw tv tpc         rv rpc          push paddr  pop rst  exp_pc        cnt hit
      // sequential advance from the reset vector, then asynchronous reset mid-run
      step(1, 0, 0,          0, 0,          0, 0,      0, 0, 32'h1000,     0, 0);
      step(1, 0, 0,          0, 0,          0, 0,      0, 0, 32'h1004,     0, 0);
      step(1, 0, 0,          0, 0,          0, 0,      0, 0, 32'h1008,     0, 0);
      step(0, 0, 0,          0, 0,          0, 0,      0, 0, 32'h100C,     0, 0);
      step(1, 0, 0,          0, 0,          0, 0,      0, 1, 32'h1000,     0, 0);
      step(0, 0, 0,          0, 0,          0, 0,      0, 0, 32'h1000,     0, 0);
      // stall then redirect; trap beats redirect
      step(0, 0, 0,          1, 32'h20,     0, 0,      0, 0, 32'h1000,     0, 0);
      step(0, 0, 0,          0, 0,          0, 0,      0, 0, 32'h20,       0, 0);
      step(0, 0, 0,          0, 0,          0, 0,      0, 0, 32'h20,       0, 0);
      step(0, 0, 0,          1, 32'h80,     0, 0,      0, 0, 32'h20,       0, 0);
      step(0, 1, 32'h100,    1, 32'h200,    0, 0,      0, 0, 32'h80,       0, 0);
      // five pushes saturate the count; pops return newest first, fifth pop falls through
      step(1, 0, 0,          0, 0,          1, 32'h10, 0, 0, 32'h100,      0, 0);
      step(1, 0, 0,          0, 0,          1, 32'h20, 0, 0, 32'h104,      1, 0);
      step(1, 0, 0,          0, 0,          1, 32'h30, 0, 0, 32'h108,      2, 0);
      step(1, 0, 0,          0, 0,          1, 32'h40, 0, 0, 32'h10C,      3, 0);
      step(1, 0, 0,          0, 0,          1, 32'h50, 0, 0, 32'h110,      4, 0);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h114,      4, 1);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h50,       3, 1);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h40,       2, 1);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h30,       1, 1);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h20,       0, 0);
      // simultaneous push and pop replaces the top
      step(1, 0, 0,          0, 0,          1, 32'h10, 0, 0, 32'h24,       0, 0);
      step(1, 0, 0,          0, 0,          1, 32'h20, 0, 0, 32'h28,       1, 0);
      step(1, 0, 0,          0, 0,          1, 32'h99, 1, 0, 32'h2C,       2, 1);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h20,       2, 1);
      step(1, 0, 0,          0, 0,          0, 0,      0, 0, 32'h99,       1, 0);
      // fill to three, then a trap with a pop flushes the stack
      step(1, 0, 0,          0, 0,          1, 32'h200, 0, 0, 32'h9D,      1, 0);
      step(1, 0, 0,          0, 0,          1, 32'h300, 0, 0, 32'hA1,      2, 0);
      step(1, 1, 32'h400,    0, 0,          0, 0,      1, 0, 32'hA5,       3, 0);
      // redirect drops push and pop from the wrong path
      step(1, 0, 0,          0, 0,          1, 32'h600, 0, 0, 32'h400,     0, 0);
      step(1, 0, 0,          1, 32'h500,    1, 32'h700, 0, 0, 32'h404,     1, 0);
      step(1, 0, 0,          1, 32'hFFFF_FFFC, 0, 0,   1, 0, 32'h500,      1, 0);
      // wrap past the top of the address space, misaligned redirect target
      step(1, 0, 0,          0, 0,          0, 0,      0, 0, 32'hFFFF_FFFC, 1, 0);
      step(1, 0, 0,          1, 32'h42,     0, 0,      0, 0, 32'h0,        1, 0);
      step(0, 0, 0,          0, 0,          0, 0,      0, 0, 32'h42,       1, 0);
      // a pop during a stall is flagged but does not move the stack
      step(0, 0, 0,          0, 0,          0, 0,      1, 0, 32'h42,       1, 1);
      step(1, 0, 0,          0, 0,          0, 0,      1, 0, 32'h42,       1, 1);
      step(0, 0, 0,          0, 0,          0, 0,      0, 0, 32'h600,      0, 0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: queue depth %0d required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-stage program-counter generator. Successor to the single-source PC register.
- Holds the fetch PC and arbitrates next-PC sources by fixed priority: trap, resolved redirect, return-address prediction, sequential.
- Contains a small circular return-address stack (RAS) fed by the decode stage.
- Sits at the front of the pipeline; drives the instruction-memory address and the IF/ID PC.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  1 = fetch may advance; 0 = stall (hold PC) unless trap_valid or redirect_valid is high.
- trap_valid  in  1  trap/exception redirect request.
- trap_pc  in  XLEN  trap handler target.
- redirect_valid  in  1  resolved branch/jump redirect from EX (misprediction or taken branch).
- redirect_pc  in  XLEN  resolved target.
- ras_push  in  1  decode saw a call; push ras_push_addr.
- ras_push_addr  in  XLEN  return address (call PC + 4).
- ras_pop  in  1  decode saw a return; use the RAS top as the next PC.
- pc  out  XLEN  current fetch PC (registered).
- ras_hit  out  1  combinational: ras_pop high, RAS not empty, and no trap or redirect this cycle.
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries (registered).
- pc_misaligned  out  1  combinational: pc[1:0] != 2'b00.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_VECTOR, ras_count = 0, stack pointer = 0. RAS data entries are not cleared.
  - Reset asserted mid-operation overrides every other input.
  - Outputs after reset: ras_hit = 0, pc_misaligned = RESET_VECTOR[1:0] != 0.
- Next-PC priority, evaluated each rising edge:
  1. trap_valid: pc <= trap_pc. Ignores pc_write. Clears RAS (ras_count <= 0, sp <= 0). Ignores ras_push and ras_pop.
  2. redirect_valid: pc <= redirect_pc. Ignores pc_write. RAS unchanged; push and pop are ignored (they came from the wrong path).
  3. pc_write && ras_hit: pc <= RAS top, i.e. entry[sp-1] mod RAS_DEPTH.
  4. pc_write: pc <= pc + INC, wrapping modulo 2^XLEN.
  5. Otherwise pc holds.
- Latency:
  - Every update is one cycle; pc reflects the selected source in the cycle after the edge.
  - No combinational path from any input to pc.
- RAS update (only when no trap or redirect, and pc_write = 1):
  - Push only: entry[sp] <= ras_push_addr; sp <= sp+1 mod RAS_DEPTH; ras_count <= min(ras_count+1, RAS_DEPTH).
  - Push when full: the oldest entry is overwritten (circular wrap); ras_count stays RAS_DEPTH.
  - Pop only, not empty: sp <= sp-1 mod RAS_DEPTH; ras_count <= ras_count-1.
  - Pop when empty: ras_hit = 0, PC takes the sequential path, RAS unchanged (no underflow).
  - Push and pop in the same cycle:
    - Not empty: the pop uses the old top as the target; entry[sp-1] <= ras_push_addr; sp and ras_count unchanged.
    - Empty: push-only behaviour.
  - pc_write = 0: push and pop are ignored; RAS holds.
- Arithmetic:
  - All PC math is XLEN-bit unsigned; no sign extension.
  - Targets are taken verbatim; alignment is not corrected. pc_misaligned flags misalignment for the trap logic downstream.

Test Plan:
- Reset with RESET_VECTOR = 32'h0000_1000, then pc_write = 1 for 3 cycles -> pc goes 0x1000, 0x1004, 0x1008, 0x100C. Assert reset mid-cycle -> pc is 0x1000 immediately (asynchronous), ras_count = 0.
- pc = 0x20, pc_write = 0 for 2 cycles, then redirect_valid = 1 with redirect_pc = 0x80 while pc_write = 0 -> pc holds 0x20 for 2 cycles, then becomes 0x80. Repeat with trap_valid = 1, trap_pc = 0x100, and redirect_valid = 1 in the same cycle -> pc = 0x100.
- With RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_count saturates at 4. Then 4 pops -> next PCs 0x50, 0x40, 0x30, 0x20, each with ras_hit = 1. A 5th pop -> ras_hit = 0 and pc = pc + 4.
- Stack holds 0x10, 0x20; assert ras_push = 1 (addr 0x99) and ras_pop = 1 together -> next pc = 0x20, ras_count stays 2, following pop yields 0x99.
- ras_count = 3, then trap_valid = 1 with ras_pop = 1 -> pc = trap_pc, ras_count = 0. Separately, redirect_valid = 1 with ras_push = 1 -> ras_count unchanged.
- pc = 32'hFFFF_FFFC, pc_write = 1 -> pc wraps to 0x0. redirect_pc = 0x42 -> pc = 0x42 and pc_misaligned = 1.
